csr_apb_ctrl: RTL

// APB3 slave front-end and control sequencer for the CSR unit; sits directly upstream of cs_registers.

---
 rtl/csr_pkg.sv | 43 ++++
 rtl/csr_push_seq.sv | 51 +++++
 rtl/csr_apb_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the CSR APB front-end: register map and FSM encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package csr_pkg;

    // Byte addresses of the CSR map; address bits [1:0] are ignored by the decoder.
    localparam int unsigned ADDR_CTRL   = 32'h00;
    localparam int unsigned ADDR_DATA0  = 32'h04;
    localparam int unsigned ADDR_DATA1  = 32'h08;
    localparam int unsigned ADDR_RESULT = 32'h0C;
    localparam int unsigned ADDR_STATUS = 32'h10;

    typedef enum logic [2:0] {
        IDLE,
        W_ACC,
        R_ACC,
        R_WAIT,
        R_POP,
        R_CAP
    } apb_state_t;

    typedef enum logic [1:0] {
        P_IDLE,
        P_PUSH,
        P_CLR
    } push_state_t;

    // Decoded register target; REG_NONE marks an unmapped address and also
    // selects an all-zero read-data mux.
    typedef enum logic [2:0] {
        REG_NONE,
        REG_CTRL,
        REG_DATA0,
        REG_DATA1,
        REG_RESULT,
        REG_STATUS
    } reg_sel_t;

    function automatic logic reg_is_rw(input reg_sel_t r);
        return (r == REG_CTRL) || (r == REG_DATA0) || (r == REG_DATA1);
    endfunction

endpackage

// File: rtl/csr_push_seq.sv
// Push sequencer: issues exactly one FIFO_IN push per start_bit assertion.
// Latency: w_en_in pulses the cycle after start_bit=1 is seen with full_in=0.
// Backpressure: waits indefinitely in idle while full_in=1; no push is dropped.
//
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   start_bit  - CTRL[0]; expected to self-clear after the push
//   full_in    - FIFO_IN full
//   w_en_in    - one-cycle push strobe (registered)
//   busy       - high whenever the sequencer is not idle
module csr_push_seq
    import csr_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start_bit,
    input  logic full_in,
    output logic w_en_in,
    output logic busy
);

    push_state_t state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= P_IDLE;
            w_en_in <= 1'b0;
        end else begin
            w_en_in <= 1'b0;
            case (state)
                P_IDLE: begin
                    if (start_bit && !full_in) begin
                        state   <= P_PUSH;
                        w_en_in <= 1'b1;
                    end
                end
                P_PUSH: state <= P_CLR;
                // Wait for start_bit to drop so one start yields one push.
                P_CLR: begin
                    if (!start_bit) begin
                        state <= P_IDLE;
                    end
                end
                default: state <= P_IDLE;
            endcase
        end
    end

    assign busy = (state != P_IDLE);

endmodule

// File: rtl/csr_apb_ctrl.sv
// APB3 slave front-end for the CSR unit: write strobes, read mux, FIFO_OUT pop sequencing.
// Latency: writes / register reads complete in 2 APB cycles; RESULT reads take >= 4 cycles.
// Backpressure: RESULT reads insert wait states until FIFO_OUT is non-empty or RD_TIMEOUT expires.
//
// Ports:
//   clk, rst                     - clock, asynchronous active-high reset
//   psel, penable, pwrite, paddr - APB request (paddr[1:0] ignored)
//   pready, pslverr, prdata      - APB response; prdata is zero while pready=0
//   en_ctrl, en_data0, en_data1  - one-cycle register write strobes
//   w_en_in                      - FIFO_IN push strobe (from the push sequencer)
//   r_en_out, pop_out            - RESULT register hold, FIFO_OUT pop strobe
//   start_bit, full_in, empty_out- CTRL[0] and FIFO flags
//   ctrl_rd .. fifo_out_status   - register readback sources
module csr_apb_ctrl
    import csr_pkg::*;
#(
    parameter int APB_ADDR_SIZE  = 8,
    parameter int APB_BUS_SIZE   = 32,
    parameter int FIFO_OUT_WIDTH = 25,
    parameter int RD_TIMEOUT     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [APB_ADDR_SIZE-1:0]  paddr,
    output logic                      pready,
    output logic                      pslverr,
    output logic [APB_BUS_SIZE-1:0]   prdata,
    output logic                      en_ctrl,
    output logic                      en_data0,
    output logic                      en_data1,
    output logic                      w_en_in,
    output logic                      r_en_out,
    output logic                      pop_out,
    input  logic                      start_bit,
    input  logic                      full_in,
    input  logic                      empty_out,
    input  logic [APB_BUS_SIZE-1:0]   ctrl_rd,
    input  logic [APB_BUS_SIZE-1:0]   data0_rd,
    input  logic [APB_BUS_SIZE-1:0]   data1_rd,
    input  logic [FIFO_OUT_WIDTH-1:0] final_result,
    input  logic [FIFO_OUT_WIDTH-1:0] fifo_out_status
);

    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

    apb_state_t               state;
    reg_sel_t                 dec_sel;
    reg_sel_t                 rd_sel;
    logic [CNT_W-1:0]         rd_cnt;
    logic [CNT_W-1:0]         rd_cnt_nxt;
    logic [APB_ADDR_SIZE-1:0] addr_aligned;
    logic                     push_busy;
    logic                     wr_err;

    csr_push_seq u_push_seq (
        .clk       (clk),
        .rst       (rst),
        .start_bit (start_bit),
        .full_in   (full_in),
        .w_en_in   (w_en_in),
        .busy      (push_busy)
    );

    // Mask the byte-lane bits rather than slicing them off, so the whole bus is decoded.
    assign addr_aligned = paddr & ~APB_ADDR_SIZE'(3);

    always_comb begin
        dec_sel = REG_NONE;
        if      (addr_aligned == APB_ADDR_SIZE'(ADDR_CTRL))   dec_sel = REG_CTRL;
        else if (addr_aligned == APB_ADDR_SIZE'(ADDR_DATA0))  dec_sel = REG_DATA0;
        else if (addr_aligned == APB_ADDR_SIZE'(ADDR_DATA1))  dec_sel = REG_DATA1;
        else if (addr_aligned == APB_ADDR_SIZE'(ADDR_RESULT)) dec_sel = REG_RESULT;
        else if (addr_aligned == APB_ADDR_SIZE'(ADDR_STATUS)) dec_sel = REG_STATUS;
    end

    // Writes are refused while a start is pending or the push sequencer is
    // mid-flight, so CTRL/DATA cannot change under an in-progress push. A
    // start_bit rising in the setup cycle is caught here as well.
    assign wr_err = !reg_is_rw(dec_sel) || start_bit || push_busy;

    assign rd_cnt_nxt = rd_cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rd_sel   <= REG_NONE;
            rd_cnt   <= '0;
            pready   <= 1'b0;
            pslverr  <= 1'b0;
            en_ctrl  <= 1'b0;
            en_data0 <= 1'b0;
            en_data1 <= 1'b0;
            r_en_out <= 1'b0;
            pop_out  <= 1'b0;
        end else begin
            pready   <= 1'b0;
            pslverr  <= 1'b0;
            en_ctrl  <= 1'b0;
            en_data0 <= 1'b0;
            en_data1 <= 1'b0;
            pop_out  <= 1'b0;
            rd_sel   <= REG_NONE;
            case (state)
                // Decode in the setup cycle so the access cycle already carries
                // pready and the strobes (zero-wait transfers).
                IDLE: begin
                    r_en_out <= 1'b0;
                    if (psel && !penable) begin
                        if (pwrite) begin
                            state  <= W_ACC;
                            pready <= 1'b1;
                            if (wr_err) begin
                                pslverr <= 1'b1;
                            end else begin
                                en_ctrl  <= (dec_sel == REG_CTRL);
                                en_data0 <= (dec_sel == REG_DATA0);
                                en_data1 <= (dec_sel == REG_DATA1);
                            end
                        end else if (dec_sel == REG_RESULT) begin
                            state  <= R_WAIT;
                            rd_cnt <= '0;
                        end else begin
                            state   <= R_ACC;
                            pready  <= 1'b1;
                            pslverr <= (dec_sel == REG_NONE);
                            rd_sel  <= dec_sel;
                        end
                    end
                end
                W_ACC, R_ACC: state <= IDLE;
                R_WAIT: begin
                    if (!psel) begin
                        state <= IDLE;
                    end else if (!empty_out) begin
                        state    <= R_POP;
                        pop_out  <= 1'b1;
                        r_en_out <= 1'b1;
                    end else begin
                        rd_cnt <= rd_cnt_nxt;
                        // Timeout completes straight from here; the pready cycle is spent in IDLE.
                        if (rd_cnt_nxt == CNT_W'(RD_TIMEOUT)) begin
                            state   <= IDLE;
                            pready  <= 1'b1;
                            pslverr <= 1'b1;
                        end
                    end
                end
                // final_result loads the head word at the end of this cycle, so
                // the response is presented one cycle later.
                R_POP: begin
                    state  <= R_CAP;
                    pready <= 1'b1;
                    rd_sel <= REG_RESULT;
                end
                R_CAP: begin
                    state    <= IDLE;
                    r_en_out <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // rd_sel is only non-NONE during a pready cycle, which keeps prdata zero otherwise.
    always_comb begin
        prdata = '0;
        case (rd_sel)
            REG_CTRL:   prdata = ctrl_rd;
            REG_DATA0:  prdata = data0_rd;
            REG_DATA1:  prdata = data1_rd;
            REG_RESULT: prdata = APB_BUS_SIZE'(final_result);
            REG_STATUS: prdata = APB_BUS_SIZE'(fifo_out_status);
            default:    prdata = '0;
        endcase
    end

endmodule
